// File: rtl/disp_timing_gen.sv
// rtl/disp_timing_gen.sv - display timing generator with frame_buf read issue and aligned pixel output
module disp_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int RD_LAT   = 1,
    parameter int CNT_W    = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        en,
    input  logic [23:0] pix_in,
    output logic        rd_en_out,
    output logic [23:0] rgb_out,
    output logic        de,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DL      = RD_LAT + 1;

    localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_ACT  = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT  = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] H_SS   = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] H_SE   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CNT_W-1:0] V_SS   = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] V_SE   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic             run, act, hs, vs, fs;
    logic [DL-1:0]    act_dly_q, hs_dly_q, vs_dly_q, fs_dly_q;
    logic             rd_en_q, de_q, hsync_q, vsync_q, fs_q;
    logic [23:0]      rgb_q;

    // Stage-0 decode; everything is blank while idle even though counters sit at 0.
    always_comb begin
        run = (state_q == ST_RUN);
        act = run && (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
        hs  = run && (h_cnt_q >= H_SS) && (h_cnt_q < H_SE);
        vs  = run && (v_cnt_q >= V_SS) && (v_cnt_q < V_SE);
        fs  = run && (h_cnt_q == '0) && (v_cnt_q == '0);
    end

    always_comb begin
        state_d = state_q;
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (state_q == ST_IDLE) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
            if (en) state_d = ST_RUN;
        end else if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            if (v_cnt_q == V_LAST) begin
                v_cnt_d = '0;
                if (!en) state_d = ST_IDLE;
            end else begin
                v_cnt_d = v_cnt_q + CNT_W'(1);
            end
        end else begin
            h_cnt_d = h_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            h_cnt_q   <= '0;
            v_cnt_q   <= '0;
            act_dly_q <= '0;
            hs_dly_q  <= '0;
            vs_dly_q  <= '0;
            fs_dly_q  <= '0;
            rd_en_q   <= 1'b1;
            de_q      <= 1'b0;
            rgb_q     <= '0;
            hsync_q   <= ~HS_POL;
            vsync_q   <= ~VS_POL;
            fs_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            v_cnt_q   <= v_cnt_d;
            rd_en_q   <= ~act;
            // Delay covers the rd_en register plus the frame_buf read latency.
            act_dly_q <= {act_dly_q[DL-2:0], act};
            hs_dly_q  <= {hs_dly_q[DL-2:0], hs};
            vs_dly_q  <= {vs_dly_q[DL-2:0], vs};
            fs_dly_q  <= {fs_dly_q[DL-2:0], fs};
            de_q      <= act_dly_q[DL-1];
            rgb_q     <= act_dly_q[DL-1] ? pix_in : 24'h0;
            hsync_q   <= hs_dly_q[DL-1] ? HS_POL : ~HS_POL;
            vsync_q   <= vs_dly_q[DL-1] ? VS_POL : ~VS_POL;
            fs_q      <= fs_dly_q[DL-1];
        end
    end

    assign rd_en_out   = rd_en_q;
    assign rgb_out     = rgb_q;
    assign de          = de_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign frame_start = fs_q;
endmodule

// File: tb/tb_disp_timing_gen.sv
// tb/tb_disp_timing_gen.sv - randomized bench for disp_timing_gen at RD_LAT 1 and 3
module tb_disp_timing_gen;
    localparam int HA = 4, HF = 1, HS = 2, HB = 1;
    localparam int VA = 3, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FT = HT * VT;

    typedef struct packed {
        logic        act;
        logic        hs;
        logic        vs;
        logic        fs;
        logic [23:0] pix;
    } rec_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [23:0] pix0, pix1;
    logic        rd_w [2];
    logic [23:0] rgb_w [2];
    logic        de_w [2];
    logic        hs_w [2];
    logic        vs_w [2];
    logic        fs_w [2];

    int          n_checks = 0;
    int          n_errors = 0;

    // Reference state: whether the frame is running and the position within it.
    bit          m_run;
    int          m_pos;
    rec_t        hist [2][8];
    logic        rdh [2][8];
    logic [23:0] rd_cnt [2];
    logic [23:0] fb_cnt [2];
    int          lv [2] = '{3, 5};
    int          rl [2] = '{1, 3};

    always #5 clk = ~clk;

    disp_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(1), .CNT_W(12)
    ) u_dut_lat1 (
        .clk(clk), .reset(reset), .en(en), .pix_in(pix0),
        .rd_en_out(rd_w[0]), .rgb_out(rgb_w[0]), .de(de_w[0]),
        .hsync(hs_w[0]), .vsync(vs_w[0]), .frame_start(fs_w[0])
    );

    disp_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .HS_POL(1'b0), .VS_POL(1'b0), .RD_LAT(3), .CNT_W(12)
    ) u_dut_lat3 (
        .clk(clk), .reset(reset), .en(en), .pix_in(pix1),
        .rd_en_out(rd_w[1]), .rgb_out(rgb_w[1]), .de(de_w[1]),
        .hsync(hs_w[1]), .vsync(vs_w[1]), .frame_start(fs_w[1])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic rec_t decode(input bit r, input int p);
        rec_t x;
        int   h;
        int   v;
        x = '0;
        h = p % HT;
        v = p / HT;
        if (r) begin
            x.act = (h < HA) && (v < VA);
            x.hs  = (h >= HA + HF) && (h < HA + HF + HS);
            x.vs  = (v >= VA + VF) && (v < VA + VF + VS);
            x.fs  = (p == 0);
        end
        return x;
    endfunction

    task automatic clear_model();
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 8; i++) hist[d][i] = '0;
    endtask

    task automatic step(input logic r, input logic e);
        rec_t        ex;
        logic [23:0] pv;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            for (int i = 7; i > 0; i--) hist[d][i] = hist[d][i-1];
            hist[d][0] = decode(m_run, m_pos);
            if (hist[d][1].act) begin
                rd_cnt[d]++;
                hist[d][1].pix = rd_cnt[d];
            end
            ex = hist[d][lv[d]];
            check($sformatf("rd_en_out[%0d]", d), 32'(rd_w[d]), 32'(!hist[d][1].act));
            check($sformatf("de[%0d]", d), 32'(de_w[d]), 32'(ex.act));
            check($sformatf("rgb_out[%0d]", d), 32'(rgb_w[d]), ex.act ? 32'(ex.pix) : 32'h0);
            check($sformatf("hsync[%0d]", d), 32'(hs_w[d]), 32'(!ex.hs));
            check($sformatf("vsync[%0d]", d), 32'(vs_w[d]), 32'(!ex.vs));
            check($sformatf("frame_start[%0d]", d), 32'(fs_w[d]), 32'(ex.fs));
            for (int i = 7; i > 0; i--) rdh[d][i] = rdh[d][i-1];
            rdh[d][0] = rd_w[d];
            if (rdh[d][rl[d]] == 1'b0) begin
                fb_cnt[d]++;
                pv = fb_cnt[d];
            end else begin
                pv = 24'h0;
            end
            if (d == 0) pix0 = pv;
            else        pix1 = pv;
        end
        reset = r;
        en    = e;
        if (!r) begin
            m_run = 1'b0;
            m_pos = 0;
            clear_model();
        end else if (!m_run) begin
            if (e) begin
                m_run = 1'b1;
                m_pos = 0;
            end
        end else if (m_pos == FT - 1) begin
            m_pos = 0;
            if (!e) m_run = 1'b0;
        end else begin
            m_pos++;
        end
    endtask

    initial begin
        reset = 1'b0;
        en    = 1'b0;
        pix0  = 24'h0;
        pix1  = 24'h0;
        repeat (3) @(posedge clk);
        m_run = 1'b0;
        m_pos = 0;
        clear_model();
        for (int d = 0; d < 2; d++) begin
            rd_cnt[d] = 24'h0;
            fb_cnt[d] = 24'h0;
            for (int i = 0; i < 8; i++) rdh[d][i] = 1'b1;
        end

        repeat (2) step(1'b0, 1'b0);
        repeat (100) step(1'b1, 1'b1);
        for (int n = 0; n < 100 && !(m_run && m_pos == HT); n++) step(1'b1, 1'b1);
        repeat (80) step(1'b1, 1'b0);
        repeat (30) step(1'b1, 1'b1);
        for (int n = 0; n < 100 && !(m_run && m_pos == HT + 2); n++) step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        repeat (60) step(1'b1, 1'b1);

        for (int n = 0; n < 1500; n++)
            step(logic'($urandom_range(0, 149) != 0), logic'($urandom_range(0, 3) != 0));
        for (int n = 0; n < 600; n++)
            step(logic'($urandom_range(0, 149) != 0), logic'($urandom_range(0, 9) < 3));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/disp_timing_gen.md
# disp_timing_gen

Display timing generator and pixel output stage directly downstream of `frame_buf`. It runs on the `frame_buf` read clock domain and generates the horizontal and vertical counters. It drives the active-low `frame_buf` read enable one pixel ahead of the active video window. It then re-times the returned 24-bit RGB pixels so that `rgb_out`, `de`, `hsync` and `vsync` leave the block mutually aligned for the panel/serializer stage.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch, in clocks
- `H_SYNC`, 96, hsync width, in clocks
- `H_BP`, 48, horizontal back porch, in clocks
- `V_ACTIVE`, 480, active lines per frame
- `V_FP`, 10, vertical front porch, in lines
- `V_SYNC`, 2, vsync width, in lines
- `V_BP`, 33, vertical back porch, in lines
- `HS_POL`, 0, hsync asserted level (1 = active-high)
- `VS_POL`, 0, vsync asserted level
- `RD_LAT`, 1, cycles from a `rd_en_out`-low cycle to the matching pixel valid on `pix_in` (≥1)
- `CNT_W`, 12, counter width; must hold H_TOTAL-1 and V_TOTAL-1
- `clk`  in  1  pixel clock; also the `frame_buf` `rd_clk`
- `reset`  in  1  synchronous, active-low reset
- `en`  in  1  display enable; acted on only at frame boundaries
- `pix_in`  in  24  pixel from `frame_buf` `data_out`
- `rd_en_out`  out  1  active-low read enable to `frame_buf` `rd_en_in`
- `rgb_out`  out  24  output pixel; 0 outside active video
- `de`  out  1  data enable, high during active pixels
- `hsync`  out  1  horizontal sync, level set by `HS_POL`
- `vsync`  out  1  vertical sync, level set by `VS_POL`
- `frame_start`  out  1  one-cycle pulse aligned with the first output cycle of each frame

## Operation
- Totals: `H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP` and `V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP`.
- Line order is active, then FP, then sync, then BP. Frame order follows the same pattern.
- `h_cnt` runs from 0 to H_TOTAL-1 and wraps to 0. On wrap, `v_cnt` increments. `v_cnt` wraps to 0 after V_TOTAL-1.
- Stage-0 decode:
  - `act = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE)`
  - `hs = H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC`
  - `vs = V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC`, true for whole lines starting at `h_cnt = 0`
  - `fs = (h_cnt == 0 && v_cnt == 0)`
- States:
  - IDLE: counters held at 0. `rd_en_out = 1`. All outputs at their reset values.
  - RUN: counters advance every clock.
- Transitions:
  - IDLE → RUN when `en = 1` is sampled. The first RUN cycle has `h_cnt = 0`, `v_cnt = 0`.
  - RUN → IDLE only when `en = 0` is sampled at `h_cnt = H_TOTAL-1`, `v_cnt = V_TOTAL-1`.
  - `en` low mid-frame is ignored until that boundary. `en` toggling mid-frame has no effect.
- Read issue: `rd_en_out` is registered as `~act`. It goes low for exactly H_ACTIVE consecutive cycles per active line and exactly H_ACTIVE×V_ACTIVE cycles per frame. It is never low during blanking.
- Alignment:
  - `act`, `hs`, `vs` and `fs` pass through a delay line of RD_LAT+1 registers.
  - `rgb_out` is registered from `pix_in` when the delayed `act` is 1, otherwise 0.
  - `hsync`/`vsync` = the delayed `hs`/`vs` mapped to `HS_POL`/`VS_POL`.
- On RUN → IDLE the delay line keeps shifting blank values. Because the frame end is in vertical BP, no pixel is in flight and no drain logic is needed.

## Timing
- Reset values: `rd_en_out = 1`, `rgb_out = 0`, `de = 0`, `hsync = ~HS_POL`, `vsync = ~VS_POL`, `frame_start = 0`. State = IDLE, counters = 0, delay line cleared.
- Reset low is sampled at any point, including mid-frame. On the next edge everything returns to the reset values. The frame resumes from (0,0) only after `reset = 1` and `en = 1`.
- `rd_en_out` falls 1 cycle after stage-0 `act` goes true.
- `de` rises RD_LAT+1 cycles after `rd_en_out` falls. `de`, `rgb_out`, `hsync`, `vsync` and `frame_start` change on the same edge.
- `pix_in` is sampled exactly RD_LAT cycles after the corresponding `rd_en_out`-low cycle.
- First `frame_start` after enable: `en` is sampled at edge 0, the first RUN cycle is edge 1, and the pulse appears RD_LAT+2 cycles after edge 0.
- Zero-length porches are legal (`H_FP = 0` etc.). `H_SYNC`, `V_SYNC`, `H_ACTIVE` and `V_ACTIVE` are ≥ 1.

## Test plan
Small parameter set: `H_ACTIVE = 4`, `H_FP = 1`, `H_SYNC = 2`, `H_BP = 1`, `V_ACTIVE = 3`, `V_FP = 1`, `V_SYNC = 1`, `V_BP = 1`, `RD_LAT = 1`, giving 8×6 = 48 clocks/frame. A `frame_buf` model returns an incrementing pixel 24'h1, 24'h2, … per read.

- Reset then `en = 1`:
  - `rd_en_out` is low for 4 cycles, high for 4, and repeats for 3 lines.
  - `de` follows 2 cycles later. `rgb_out` = 1,2,3,4 on line 0 and reaches 24'hC at the last active pixel. `frame_start` pulses once per 48 clocks.
- Sync check: `hsync` is low (`HS_POL = 0`) for 2 cycles starting 5 clocks after line start. `vsync` is low for the 8 clocks of line 4. There are 12 `rd_en_out`-low cycles per frame.
- `en` dropped at `v_cnt = 1`:
  - The current frame completes with all 12 pixels.
  - After the last BP clock, `rd_en_out` stays 1, `de` and `rgb_out` stay 0, and no further `frame_start` occurs.
- `en` re-asserted while IDLE: the next frame starts at (0,0) and `frame_start` appears 3 cycles after `en` is sampled high.
- `reset = 0` mid-active-line: on the next edge `rd_en_out = 1`, `de = 0` and `rgb_out = 0`. After release with `en = 1`, a full clean frame follows.
- `RD_LAT = 3`: `de` rises 4 cycles after `rd_en_out` falls, and the pixel sequence is unchanged.
